// File: rtl/load_unit_pkg.sv
// Shared encodings for the load alignment unit: access sizes, FSM states
// and a small helper that turns a size code into a byte count.
package load_unit_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE0 = 3'd1,
        WAIT0  = 3'd2,
        ISSUE1 = 3'd3,
        WAIT1  = 3'd4,
        DONE   = 3'd5
    } state_e;

    // Byte count of an access: 1, 2, 4 or 8.
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational field extraction: shifts the two-word window {w1,w0} right
// by the byte offset, keeps the addressed field and sign- or zero-extends it
// to the full word width.
module load_extend
    import load_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [2*DATA_W-1:0] merged,
    input  logic [OFF_W-1:0]    off,
    input  logic [1:0]          size,
    input  logic                sgn,
    output logic [DATA_W-1:0]   data
);

    logic [DATA_W-1:0] field;
    logic              top;
    int                nbits;

    // Align the field to bit 0, then overwrite everything above it with the fill bit.
    always_comb begin
        field = DATA_W'(merged >> {off, 3'b000});
        nbits = 8 << size;
        case (size)
            SZ_BYTE: top = field[7];
            SZ_HALF: top = field[15];
            SZ_WORD: top = field[31];
            default: top = field[DATA_W-1];
        endcase
        data = field;
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= nbits) begin
                data[i] = sgn & top;
            end
        end
    end

endmodule

// File: rtl/load_align_unit.sv
// Sequential load aligner. Accepts a byte-addressed load, performs one or two
// aligned word reads, merges them and returns the extended field.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and its payload stable until that edge;
// ready never depends combinationally on the other side's valid. req_ready is
// high only in IDLE; resp_valid is high only in DONE, where resp_data and
// resp_err stay fixed until resp_ready is seen.
module load_align_unit
    import load_unit_pkg::*;
#(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 32,
    parameter int MEM_LATENCY      = 1,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output state_e            fsm_state
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_LATENCY);
    localparam logic [4:0]        NB_5     = 5'(NB);
    localparam logic [ADDR_W-1:0] NB_A     = ADDR_W'(NB);

    state_e            state;
    state_e            state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic              straddle_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] w0;
    logic [DATA_W-1:0] w1;
    logic [DATA_W-1:0] ext_data;

    logic [4:0]        span;
    logic              size_ok;
    logic              straddle_in;
    logic              err_in;
    logic              accept;
    logic              last_beat;
    logic [ADDR_W-1:0] base;

    // Classify the incoming request: does it cross a word, and is it legal here.
    always_comb begin
        span        = 5'(req_addr[OFF_W-1:0]) + 5'(size_bytes(req_size));
        straddle_in = span > NB_5;
        size_ok     = (req_size != SZ_DWORD) || (DATA_W == 64);
        err_in      = !size_ok || (straddle_in && (ALLOW_MISALIGNED == 0));
    end

    assign accept    = req_valid && (state == IDLE);
    assign last_beat = (cnt == CNT_W'(1));
    assign base      = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and state-decoded handshake/memory strobes.
    always_comb begin
        state_n    = state;
        req_ready  = 1'b0;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_n = err_in ? DONE : ISSUE0;
                end
            end
            ISSUE0: begin
                mem_rd   = 1'b1;
                mem_addr = base;
                state_n  = WAIT0;
            end
            WAIT0: begin
                if (last_beat) begin
                    state_n = straddle_q ? ISSUE1 : DONE;
                end
            end
            ISSUE1: begin
                mem_rd   = 1'b1;
                mem_addr = base + NB_A;
                state_n  = WAIT1;
            end
            WAIT1: begin
                if (last_beat) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Request latch, read-latency counter and captured memory words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            size_q     <= '0;
            sgn_q      <= 1'b0;
            straddle_q <= 1'b0;
            err_q      <= 1'b0;
            cnt        <= '0;
            w0         <= '0;
            w1         <= '0;
        end else begin
            if (accept) begin
                addr_q     <= req_addr;
                size_q     <= req_size;
                sgn_q      <= req_signed;
                straddle_q <= straddle_in;
                err_q      <= err_in;
                w0         <= '0;
                w1         <= '0;
            end
            case (state)
                ISSUE0, ISSUE1: cnt <= CNT_LOAD;
                WAIT0: begin
                    cnt <= cnt - CNT_W'(1);
                    if (last_beat) begin
                        w0 <= mem_rdata;
                    end
                end
                WAIT1: begin
                    cnt <= cnt - CNT_W'(1);
                    if (last_beat) begin
                        w1 <= mem_rdata;
                    end
                end
                default: cnt <= cnt;
            endcase
        end
    end

    load_extend #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_extend (
        .merged ({w1, w0}),
        .off    (addr_q[OFF_W-1:0]),
        .size   (size_q),
        .sgn    (sgn_q),
        .data   (ext_data)
    );

    // Response is only driven while it is being offered; errors return zero.
    assign resp_data = (resp_valid && !err_q) ? ext_data : '0;
    assign resp_err  = resp_valid && err_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit. Three instances share the clock, reset and request
// payload: [0] 32-bit misaligned-capable, [1] 32-bit misaligned-forbidden,
// [2] 64-bit with a 3-cycle memory. Expected results come from a byte-level
// memory model that gathers the addressed bytes directly.
module tb_load_align_unit;
    import load_unit_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        req_valid [3];
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        resp_ready;
    logic        req_ready [3];
    logic        mem_rd [3];
    logic        resp_valid [3];
    logic        resp_err [3];
    logic [31:0] mem_addr [3];
    state_e      fsm_state [3];
    logic [31:0] mrd0, mrd1, rsp0, rsp1;
    logic [63:0] mrd2, rsp2;
    logic [63:0] obs_data [3];

    assign obs_data[0] = {32'h0, rsp0};
    assign obs_data[1] = {32'h0, rsp1};
    assign obs_data[2] = rsp2;

    load_align_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LATENCY(1), .ALLOW_MISALIGNED(1)) u_mis (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .mem_rd(mem_rd[0]), .mem_addr(mem_addr[0]), .mem_rdata(mrd0),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready), .resp_data(rsp0),
        .resp_err(resp_err[0]), .fsm_state(fsm_state[0])
    );

    load_align_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LATENCY(1), .ALLOW_MISALIGNED(0)) u_nomis (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .mem_rd(mem_rd[1]), .mem_addr(mem_addr[1]), .mem_rdata(mrd1),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready), .resp_data(rsp1),
        .resp_err(resp_err[1]), .fsm_state(fsm_state[1])
    );

    load_align_unit #(.DATA_W(64), .ADDR_W(32), .MEM_LATENCY(3), .ALLOW_MISALIGNED(1)) u_w64 (
        .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .mem_rd(mem_rd[2]), .mem_addr(mem_addr[2]), .mem_rdata(mrd2),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready), .resp_data(rsp2),
        .resp_err(resp_err[2]), .fsm_state(fsm_state[2])
    );

    function automatic int lat_of(input int k);
        return (k == 2) ? 3 : 1;
    endfunction

    function automatic int nb_of(input int k);
        return (k == 2) ? 8 : 4;
    endfunction

    function automatic bit allow_of(input int k);
        return (k == 1) ? 1'b0 : 1'b1;
    endfunction

    // ---------------- memory model ----------------
    logic [7:0]  mem_b [logic [31:0]];
    logic        hv [3][5];
    logic [31:0] ha [3][5];
    logic [33:0] rd_log [$];

    function automatic logic [63:0] read_word(input logic [31:0] a, input int nb);
        logic [63:0] w;
        w = '0;
        for (int b = 0; b < nb; b++) begin
            w[8*b +: 8] = mem_b.exists(a + 32'(b)) ? mem_b[a + 32'(b)] : 8'h00;
        end
        return w;
    endfunction

    task automatic put_word(input logic [31:0] a, input logic [31:0] v);
        for (int b = 0; b < 4; b++) begin
            mem_b[a + 32'(b)] = v[8*b +: 8];
        end
    endtask

    // Read data appears exactly lat cycles after the strobe; junk otherwise.
    always @(negedge clk) begin
        logic [63:0] d;
        for (int k = 0; k < 3; k++) begin
            for (int j = 4; j > 0; j--) begin
                hv[k][j] = hv[k][j-1];
                ha[k][j] = ha[k][j-1];
            end
            hv[k][0] = mem_rd[k];
            ha[k][0] = mem_addr[k];
            if (mem_rd[k] === 1'b1) rd_log.push_back({2'(k), mem_addr[k]});
            if (hv[k][lat_of(k)] === 1'b1) d = read_word(ha[k][lat_of(k)], nb_of(k));
            else d = {$urandom, $urandom};
            case (k)
                0: mrd0 = d[31:0];
                1: mrd1 = d[31:0];
                default: mrd2 = d;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [63:0] last_data;
    logic        last_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: gather the addressed bytes and extend to the word width.
    task automatic ref_load(input int nb, input bit allow, input logic [31:0] addr,
                            input logic [1:0] size, input logic sgn,
                            output logic [63:0] data, output bit err, output bit strad);
        int bytes, off;
        bytes = 1 << size;
        off   = int'(addr[2:0]) % nb;
        strad = (off + bytes) > nb;
        err   = (bytes > nb) || (strad && !allow);
        data  = '0;
        if (!err) begin
            for (int i = 0; i < bytes; i++) begin
                data[8*i +: 8] = mem_b.exists(addr + 32'(i)) ? mem_b[addr + 32'(i)] : 8'h00;
            end
            if (sgn && data[8*bytes-1]) begin
                for (int i = 8 * bytes; i < 8 * nb; i++) data[i] = 1'b1;
            end
        end
    endtask

    task automatic check_reset_outputs(input int k);
        check("rst_req_ready", 64'(req_ready[k]), 64'd1);
        check("rst_mem_rd", 64'(mem_rd[k]), 64'd0);
        check("rst_mem_addr", 64'(mem_addr[k]), 64'd0);
        check("rst_resp_valid", 64'(resp_valid[k]), 64'd0);
        check("rst_resp_data", obs_data[k], 64'd0);
        check("rst_resp_err", 64'(resp_err[k]), 64'd0);
        check("rst_state", 64'(fsm_state[k]), 64'(IDLE));
    endtask

    // One full transaction on instance k, starting at a negedge with the unit idle.
    task automatic run_load(input int k, input logic [31:0] addr, input logic [1:0] size,
                            input logic sgn, input int hold);
        logic [63:0] exp_data;
        bit          exp_err, strad;
        int          exp_lat, c, nb;
        logic [31:0] base;
        nb = nb_of(k);
        ref_load(nb, allow_of(k), addr, size, sgn, exp_data, exp_err, strad);
        exp_lat = exp_err ? 1 : (strad ? 3 + 2 * lat_of(k) : 2 + lat_of(k));
        check("req_ready_idle", 64'(req_ready[k]), 64'd1);
        rd_log.delete();
        req_addr     = addr;
        req_size     = size;
        req_signed   = sgn;
        req_valid[k] = 1'b1;
        resp_ready   = (hold == 0);
        @(negedge clk);
        req_valid[k] = 1'b0;
        c = 1;
        while (resp_valid[k] !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("latency", 64'(c), 64'(exp_lat));
        check("resp_data", obs_data[k], exp_data);
        check("resp_err", 64'(resp_err[k]), 64'(exp_err));
        last_data = obs_data[k];
        last_err  = resp_err[k];
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                req_valid[k] = 1'b1;
                req_addr     = addr ^ 32'h40;
                @(negedge clk);
                check("hold_valid", 64'(resp_valid[k]), 64'd1);
                check("hold_data", obs_data[k], exp_data);
                check("hold_req_ready", 64'(req_ready[k]), 64'd0);
            end
            req_valid[k] = 1'b0;
            resp_ready   = 1'b1;
        end
        @(negedge clk);
        check("back_idle", 64'({resp_valid[k], req_ready[k]}), 64'b01);
        check("num_reads", 64'(rd_log.size()), exp_err ? 64'd0 : (strad ? 64'd2 : 64'd1));
        base = addr & ~(32'(nb) - 32'd1);
        for (int i = 0; i < rd_log.size(); i++) begin
            check("read_addr", 64'(rd_log[i]), 64'({2'(k), base + 32'(i * nb)}));
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] a, b;
        int          k;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) req_valid[i] = 1'b0;
        req_addr = '0; req_size = '0; req_signed = 1'b0; resp_ready = 1'b1;

        // Reset held with random inputs.
        repeat (4) begin
            @(negedge clk);
            req_addr = $urandom; req_size = 2'($urandom); req_signed = 1'($urandom);
            resp_ready = 1'($urandom);
            for (int i = 0; i < 3; i++) req_valid[i] = 1'($urandom);
            @(negedge clk);
            for (int i = 0; i < 3; i++) check_reset_outputs(i);
        end
        for (int i = 0; i < 3; i++) req_valid[i] = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Reset dropped while waiting for read data.
        put_word(32'h100, 32'h80FF1234);
        req_addr = 32'h100; req_size = SZ_WORD; req_signed = 1'b0; req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("issue_rd", 64'(mem_rd[0]), 64'd1);
        check("issue_addr", 64'(mem_addr[0]), 64'h100);
        @(negedge clk);
        check("wait_state", 64'(fsm_state[0]), 64'(WAIT0));
        reset = 1'b0;
        #1;
        check_reset_outputs(0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_valid", 64'(resp_valid[0]), 64'd0);
            check("post_rst_rd", 64'(mem_rd[0]), 64'd0);
        end

        // Directed cases.
        put_word(32'h100, 32'h80FF1234);
        run_load(0, 32'h103, SZ_BYTE, 1'b1, 0);
        check("byte_signed", last_data, 64'hFFFFFF80);
        put_word(32'h100, 32'h80000000);
        run_load(0, 32'h102, SZ_HALF, 1'b0, 0);
        check("half_unsigned", last_data, 64'h00008000);
        run_load(0, 32'h102, SZ_HALF, 1'b1, 0);
        check("half_signed", last_data, 64'hFFFF8000);
        put_word(32'h100, 32'h44332211);
        put_word(32'h104, 32'h88776655);
        run_load(0, 32'h101, SZ_WORD, 1'b0, 0);
        check("word_straddle", last_data, 64'h55443322);
        run_load(1, 32'h101, SZ_WORD, 1'b0, 0);
        check("misaligned_err", 64'(last_err), 64'd1);
        run_load(0, 32'h100, SZ_DWORD, 1'b0, 0);
        check("dword_on_32_err", 64'(last_err), 64'd1);
        check("dword_on_32_data", last_data, 64'd0);
        put_word(32'h8, 32'h76543210);
        put_word(32'hC, 32'hFEDCBA98);
        run_load(2, 32'h8, SZ_DWORD, 1'b1, 0);
        check("dword_on_64", last_data, 64'hFEDCBA98_76543210);
        run_load(0, 32'h101, SZ_WORD, 1'b1, 3);
        run_load(0, 32'h100, SZ_WORD, 1'b0, 0);
        check("after_hold", last_data, 64'h44332211);

        // Randomized loads across all three configurations, including address wrap.
        for (int n = 0; n < 60; n++) begin
            k = n % 3;
            if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            else a = 32'h200 + 32'($urandom_range(0, 63));
            b = a & ~(32'(nb_of(k)) - 32'd1);
            for (int i = 0; i < 2 * nb_of(k); i++) mem_b[b + 32'(i)] = 8'($urandom);
            run_load(k, a, 2'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
